l1i_memory: RTL and testbench
=============================

# l1i_memory

Single-port synchronous cacheline RAM backing the L1 instruction cache data array. It stores one full cacheline per index and sits directly under the instruction cache memory wrapper, which supplies either a fetch index or a fill index on a single shared address port. A write stores a new line. A read returns the line one clock later through a registered output that can be reset.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: index width, taken from the cache `indexSize`.
- `DATA_WIDTH`, default 256: cacheline width in bits, equal to (2**offsetSize)*8 with offsetSize 5.
- `DEPTH`, default 2**ADDR_WIDTH (256): number of cachelines.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clka`, in, 1: clock. All activity happens on the rising edge.
- `rsta`, in, 1: synchronous active-high reset of the output register only.
- `wea`, in, 1: write enable.
- `addra`, in, ADDR_WIDTH: line index for both reads and writes.
- `dina`, in, DATA_WIDTH, indexed [0:DATA_WIDTH-1]: line to write. Bit 0 is the first byte's MSB.
- `douta`, out, DATA_WIDTH, indexed [0:DATA_WIDTH-1]: registered read data.

## Operation
- Storage is an array `mem[0:DEPTH-1]` of DATA_WIDTH-bit lines, all zero at time zero.
- Each rising edge, the block evaluates the following in order:
  - If `rsta` is 1: `douta` becomes 0. If `wea` is also 1, the write to `mem[addra]` still takes place. Reset never clears the array.
  - Else if `wea` is 1: `mem[addra]` takes `dina`, and `douta` also takes `dina` (write-first).
  - Else: `douta` takes `mem[addra]`.
- Address bits are used exactly as given. There is no offset handling; the whole line is always read or written.
- Every address from 0 to DEPTH-1 is valid. No out-of-range case exists when DEPTH equals 2**ADDR_WIDTH.
- A read issues every cycle in which `wea` is 0. There is no read enable, so `douta` always reflects the last addressed line.

## Timing
- Read latency is 1 clock. If `addra` is A at rising edge N with `wea` at 0, then `douta` equals `mem[A]` during the cycle after edge N. The wrapper samples it at edge N+1.
- Write latency is 1 clock. Data written at edge N is returned by a read of the same address presented at edge N+1.
- No extra output pipeline register is permitted, because a 2-cycle RAM breaks the wrapper's bypass alignment.
- Back-to-back operations are sustained at full rate: one read or one write per cycle, in any alternation.
- Write then read of the same address on consecutive edges returns the new data.
- On a write cycle, `douta` shows the written data.
- Reset value of `douta` is 0. Reset lasting several cycles holds `douta` at 0.
- The first read after reset deasserts takes effect at the next edge.

## Structure
- A shared package `l1i_pkg` holds `L1I_OFFSET_BITS`=5, `L1I_INDEX_BITS`=8 and `L1I_LINE_BITS`=256. It also holds the tag width, 64-(offset+index)=51, and the line typedef `l1i_line_t` of [0:255].
- The parameter defaults are derived from those package constants.
- The block is a flat module with no sub-module: one memory array plus one output register.
- The memory is coded so synthesis infers block RAM: a single process, write-first, with a synchronous output reset.
- An optional `INIT_FILE` string parameter (default empty) may preload the array via `$readmemh`. When it is empty, the array is zero.

## Test plan
- Reset behaviour: assert `rsta` for 2 cycles with `douta` previously nonzero -> `douta` is 256'h0 after the first reset edge and remains 0 while `rsta` is high.
- Write then read: write `dina`=256'hDEADBEEF…(repeating) to `addra`=8'h05, then read 8'h05 with `wea`=0 on the next edge -> `douta` equals the pattern one cycle after the read edge.
- Write-first: write 256'h1234…1234 to 8'h10 -> `douta` equals 256'h1234…1234 in the cycle after the write edge.
- Alternating traffic: write to 8'h00, read 8'h05, write to 8'hFF, read 8'h00, read 8'hFF on consecutive edges. Expected `douta` in order:
  - after edge 1: the value written to 8'h00;
  - after edge 2: the 8'h05 data;
  - after edge 3: the value written to 8'hFF;
  - after edge 4: the 8'h00 data;
  - after edge 5: the 8'hFF data.
- Reset during a write: `rsta`=1 and `wea`=1 with 256'hA5…A5 at 8'h20 -> `douta` is 0. A later read of 8'h20 returns 256'hA5…A5.
- Unwritten address: read 8'h80 that has never been written -> `douta` is 256'h0.

Source files
------------

// File: rtl/l1i_pkg.sv
// Shared L1 instruction cache geometry constants and the cacheline type.
package l1i_pkg;

  localparam int L1I_OFFSET_BITS = 5;
  localparam int L1I_INDEX_BITS  = 8;
  localparam int L1I_LINE_BITS   = (2 ** L1I_OFFSET_BITS) * 8;
  localparam int L1I_TAG_BITS    = 64 - (L1I_OFFSET_BITS + L1I_INDEX_BITS);

  typedef logic [0:L1I_LINE_BITS-1] l1i_line_t;

endpackage

// File: rtl/l1i_memory.sv
// Single-port, write-first cacheline RAM for the L1I data array with a
// synchronously resettable registered output (one-cycle read latency).
module l1i_memory
  import l1i_pkg::*;
#(
  parameter int ADDR_WIDTH = L1I_INDEX_BITS,
  parameter int DATA_WIDTH = L1I_LINE_BITS,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [0:DATA_WIDTH-1] dina,
  output logic [0:DATA_WIDTH-1] douta
);

  // Declaration initialiser gives the all-zero power-up contents.
  logic [0:DATA_WIDTH-1] mem [0:DEPTH-1] = '{default: '0};

  // One process so synthesis maps this to a block RAM; reset touches only
  // the output register, never the stored lines.
  always_ff @(posedge clka) begin
    if (wea) begin
      mem[addra] <= dina;
    end
    if (rsta) begin
      douta <= '0;
    end else if (wea) begin
      douta <= dina;
    end else begin
      douta <= mem[addra];
    end
  end

endmodule

// File: tb/tb_l1i_memory.sv
// Scoreboard bench for l1i_memory: a driver pushes expected lines from an
// array model, and an independent monitor pops and compares each cycle.
module tb_l1i_memory;

  typedef logic [0:255] line_t;

  typedef struct {
    line_t exp;
    string name;
  } sb_entry_t;

  logic        clka;
  logic        rsta;
  logic        wea;
  logic [7:0]  addra;
  line_t       dina;
  line_t       douta;

  line_t       model_mem [256];
  sb_entry_t   sb_q [$];
  int          tests_run;
  int          tests_failed;

  l1i_memory dut (
    .clka  (clka),
    .rsta  (rsta),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic checkOutput(input sb_entry_t e);
    tests_run++;
    if (douta !== e.exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, douta, e.exp);
    end
  endtask

  // Drive one operation for one edge, then record what the RAM should show.
  task automatic applyStimulus(input logic rst, input logic we,
                               input logic [7:0] addr, input line_t data,
                               input string name);
    sb_entry_t e;
    @(negedge clka);
    rsta  = rst;
    wea   = we;
    addra = addr;
    dina  = data;
    @(posedge clka);
    if (we) model_mem[addr] = data;
    e.exp  = rst ? '0 : model_mem[addr];
    e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clka);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    line_t pat_dead, pat_1234, pat_a5, pat_x, pat_y, rnd;
    int    wait_cycles;
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    rsta  = 1'b1;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;

    pat_dead = {8{32'hDEADBEEF}};
    pat_1234 = {16{16'h1234}};
    pat_a5   = {32{8'hA5}};
    pat_x    = {4{64'h0123_4567_89AB_CDEF}};
    pat_y    = {4{64'hFEDC_BA98_7654_3210}};

    applyStimulus(1'b1, 1'b0, 8'h00, '0, "initial_reset");
    applyStimulus(1'b1, 1'b0, 8'h00, '0, "initial_reset_hold");

    applyStimulus(1'b0, 1'b1, 8'h05, pat_dead, "write_first_05");
    applyStimulus(1'b0, 1'b0, 8'h05, '0, "read_after_write_05");
    applyStimulus(1'b0, 1'b1, 8'h10, pat_1234, "write_first_10");

    applyStimulus(1'b1, 1'b0, 8'h10, '0, "reset_edge1");
    applyStimulus(1'b1, 1'b0, 8'h10, '0, "reset_edge2");
    applyStimulus(1'b0, 1'b0, 8'h10, '0, "read_10_after_reset");

    applyStimulus(1'b0, 1'b1, 8'h00, pat_x, "alt_write_00");
    applyStimulus(1'b0, 1'b0, 8'h05, '0, "alt_read_05");
    applyStimulus(1'b0, 1'b1, 8'hFF, pat_y, "alt_write_ff");
    applyStimulus(1'b0, 1'b0, 8'h00, '0, "alt_read_00");
    applyStimulus(1'b0, 1'b0, 8'hFF, '0, "alt_read_ff");

    applyStimulus(1'b1, 1'b1, 8'h20, pat_a5, "reset_during_write");
    applyStimulus(1'b0, 1'b0, 8'h21, '0, "read_21_unwritten");
    applyStimulus(1'b0, 1'b0, 8'h20, '0, "read_20_after_rst_write");

    applyStimulus(1'b0, 1'b0, 8'h80, '0, "read_80_unwritten");

    // Random mix over a narrow address window so reads often hit prior writes.
    for (int i = 0; i < 300; i++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
      applyStimulus(($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 2) == 0),
                    8'($urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 240 : 0)),
                    rnd, "random_op");
    end

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clka);
      wait_cycles++;
    end
    @(negedge clka);
    if (sb_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
